// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Drives the PLL reset, watches the PLL lock output, and retries the PLL when lock is not
// reached in time or is lost. Downstream logic is held in reset until lock has been
// continuously stable for a programmable number of cycles.
//
// Parameters:
//   PLL_RST_CYCLES  cycles pll_reset is held high per attempt (>= 1)
//   LOCK_TIMEOUT    cycles allowed waiting for lock before a retry (>= 1)
//   STABLE_CYCLES   consecutive locked cycles required before release (>= 1)
//   MAX_RETRIES     retries allowed before entering fault (>= 0)
//   SYNC_STAGES     synchroniser depth for locked_in (>= 2)
//
// Ports:
//   clk_in1      board clock; all logic on its rising edge
//   reset        synchronous active-high reset
//   locked_in    PLL locked output, asynchronous to clk_in1
//   pll_reset    PLL reset, active-high
//   sys_reset    active-high reset for downstream logic
//   pll_ready    high only while running with a stable lock
//   retry_count  retries consumed in the current bring-up
//   lock_lost    one-cycle pulse when lock drops while running
//   fault        sticky retry-exhaustion flag, cleared only by reset

module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 7,
    parameter int unsigned SYNC_STAGES    = 2,
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk_in1,
    input  logic               reset,
    input  logic               locked_in,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               pll_ready,
    output logic [RETRY_W-1:0] retry_count,
    output logic               lock_lost,
    output logic               fault
);

    // One shared counter, wide enough for the longest interval.
    localparam int unsigned CNT_MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                         : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX    = (CNT_MAX_AB > STABLE_CYCLES) ? CNT_MAX_AB
                                                                      : STABLE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter is 0 on the first cycle of a state, so an interval of
    // N cycles ends on the edge that sees N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic               locked_s;
    logic               retry_req;

    // ------------------------------------------------------------------------------------
    // locked_in synchroniser
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign locked_s = sync_ff[SYNC_STAGES-1];

    // ------------------------------------------------------------------------------------
    // Retry request: lock timeout while waiting, or any unlocked cycle while qualifying.
    // A lock arriving in the final wait cycle wins over the timeout.
    // ------------------------------------------------------------------------------------
    always_comb begin
        retry_req = 1'b0;
        if (state == StWaitLock) begin
            retry_req = !locked_s && (cnt == TIMEOUT_LAST);
        end else if (state == StStable) begin
            retry_req = !locked_s;
        end
    end

    // ------------------------------------------------------------------------------------
    // Supervisor FSM. Outputs are registered and updated on the same edge as the state, so
    // they always reflect the current state; lock_lost is the only pulse.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state       <= StResetPll;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            pll_ready   <= 1'b0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            lock_lost <= 1'b0;

            if (retry_req) begin
                cnt       <= '0;
                pll_reset <= 1'b1;
                sys_reset <= 1'b1;
                pll_ready <= 1'b0;
                if (retry_count == RETRY_LIMIT) begin
                    // Retries exhausted: park with the PLL held in reset.
                    state <= StFault;
                    fault <= 1'b1;
                end else begin
                    state       <= StResetPll;
                    retry_count <= retry_count + RETRY_W'(1);
                end
            end else begin
                unique case (state)
                    StResetPll: begin
                        if (cnt == RST_LAST) begin
                            state     <= StWaitLock;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    StWaitLock: begin
                        if (locked_s) begin
                            state <= StStable;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    StStable: begin
                        // Unlocked cycles are handled by retry_req above.
                        if (cnt == STABLE_LAST) begin
                            state     <= StRun;
                            cnt       <= '0;
                            sys_reset <= 1'b0;
                            pll_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    StRun: begin
                        cnt <= '0;
                        if (!locked_s) begin
                            // Lock loss starts a fresh bring-up with a full retry budget.
                            state       <= StResetPll;
                            pll_reset   <= 1'b1;
                            sys_reset   <= 1'b1;
                            pll_ready   <= 1'b0;
                            retry_count <= '0;
                            lock_lost   <= 1'b1;
                        end
                    end

                    StFault: begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        sys_reset <= 1'b1;
                        pll_ready <= 1'b0;
                        fault     <= 1'b1;
                    end

                    default: begin
                        state <= StResetPll;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor. Stimulus queues per-edge expected output vectors;
// a monitor pops and compares them against the DUT outputs after each clock edge.

module tb_pll_lock_supervisor;

    logic       clk_in1;
    logic       reset;
    logic       locked_in;
    logic       pll_reset;
    logic       sys_reset;
    logic       pll_ready;
    logic [1:0] retry_count;
    logic       lock_lost;
    logic       fault;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (50),
        .STABLE_CYCLES  (16),
        .MAX_RETRIES    (2),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_in1     (clk_in1),
        .reset       (reset),
        .locked_in   (locked_in),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .pll_ready   (pll_ready),
        .retry_count (retry_count),
        .lock_lost   (lock_lost),
        .fault       (fault)
    );

    // Vector order: {pll_reset, sys_reset, pll_ready, lock_lost, fault, retry_count[1:0]}
    logic [6:0] obs;
    assign obs = {pll_reset, sys_reset, pll_ready, lock_lost, fault, retry_count};

    typedef struct {
        int         n;
        logic [6:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    initial begin
        clk_in1 = 1'b0;
        forever #5 clk_in1 = ~clk_in1;
    end

    always @(posedge clk_in1) edge_n <= edge_n + 1;

    task automatic expect_range(input int lo, input int hi, input logic [6:0] v,
                                input string tag);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.n   = i;
            e.v   = v;
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    task automatic goto_edge(input int n);
        while (edge_n < n) @(negedge clk_in1);
    endtask

    // Monitor: compares every queued expectation tagged with the edge just taken.
    initial begin
        forever begin
            @(negedge clk_in1);
            #1;
            while (q.size() > 0 && q[0].n <= edge_n) begin
                checks++;
                if (q[0].n < edge_n) begin
                    errors++;
                    $display("FAIL %s edge %0d: expectation not checked in time (now edge %0d)",
                             q[0].tag, q[0].n, edge_n);
                end else if (obs !== q[0].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b want %b (pr,sr,rdy,ll,flt,rc)",
                             q[0].tag, q[0].n, obs, q[0].v);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at edge %0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int b2;
        int b3;
        int b4;

        reset     = 1'b1;
        locked_in = 1'b0;

        // Scenario 1: reset held for three edges, then released.
        expect_range(1, 3, 7'b1100000, "in_reset");
        goto_edge(3);
        reset = 1'b0;
        b = edge_n;
        expect_range(b + 1,  b + 3,  7'b1100000, "pll_rst_hold");
        expect_range(b + 4,  b + 15, 7'b0100000, "wait_then_stable");
        // Scenario 3: short lock in qualification -> retry 1.
        expect_range(b + 16, b + 19, 7'b1100001, "retry1_pll_rst");
        expect_range(b + 20, b + 42, 7'b0100001, "relock_qualify");
        // Release with retry_count = 1.
        expect_range(b + 43, b + 49, 7'b0010001, "run_rc1");
        // Scenario 5: lock loss in run.
        expect_range(b + 50, b + 50, 7'b1101000, "lock_lost_pulse");
        expect_range(b + 51, b + 53, 7'b1100000, "pll_rst_after_loss");
        expect_range(b + 54, b + 77, 7'b0100000, "relock2_qualify");
        expect_range(b + 78, b + 80, 7'b0010000, "run_rc0");

        goto_edge(b + 5);  locked_in = 1'b1;   // first sampled at b+6
        goto_edge(b + 13); locked_in = 1'b0;   // 8 locked cycles in qualification
        goto_edge(b + 24); locked_in = 1'b1;   // first sampled at b+25 -> release b+43
        goto_edge(b + 47); locked_in = 1'b0;   // first sampled low at b+48 -> loss at b+50
        goto_edge(b + 59); locked_in = 1'b1;   // first sampled at b+60 -> release b+78

        // Reset while running.
        goto_edge(b + 80);
        reset     = 1'b1;
        locked_in = 1'b0;
        expect_range(b + 81, b + 81, 7'b1100000, "reset_in_run");
        goto_edge(b + 81);
        reset = 1'b0;
        b2 = edge_n;

        // Scenario 6a: one lock timeout, then reset while waiting with retry_count = 1.
        expect_range(b2 + 1,  b2 + 3,  7'b1100000, "pll_rst_hold2");
        expect_range(b2 + 4,  b2 + 53, 7'b0100000, "wait_timeout1");
        expect_range(b2 + 54, b2 + 57, 7'b1100001, "timeout_retry1");
        expect_range(b2 + 58, b2 + 60, 7'b0100001, "wait_rc1");
        expect_range(b2 + 61, b2 + 61, 7'b1100000, "reset_in_wait");
        goto_edge(b2 + 60);
        reset = 1'b1;
        goto_edge(b2 + 61);
        reset = 1'b0;
        b3 = edge_n;

        // Scenario 4: never locks -> fault at release + 162.
        expect_range(b3 + 1,   b3 + 3,   7'b1100000, "pll_rst_hold3");
        expect_range(b3 + 4,   b3 + 53,  7'b0100000, "nolock_wait0");
        expect_range(b3 + 54,  b3 + 57,  7'b1100001, "nolock_retry1");
        expect_range(b3 + 58,  b3 + 107, 7'b0100001, "nolock_wait1");
        expect_range(b3 + 108, b3 + 111, 7'b1100010, "nolock_retry2");
        expect_range(b3 + 112, b3 + 161, 7'b0100010, "nolock_wait2");
        expect_range(b3 + 162, b3 + 180, 7'b1100110, "fault_sticky");

        // Scenario 6b: reset while in fault.
        goto_edge(b3 + 180);
        reset = 1'b1;
        expect_range(b3 + 181, b3 + 181, 7'b1100000, "reset_in_fault");
        goto_edge(b3 + 181);
        reset = 1'b0;
        b4 = edge_n;
        expect_range(b4 + 1, b4 + 3, 7'b1100000, "pll_rst_hold4");
        expect_range(b4 + 4, b4 + 4, 7'b0100000, "pll_rst_fall4");

        goto_edge(b4 + 6);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
